// File: rtl/pc_controller_pkg.sv
// Shared constants for the program-counter stage: next-PC select codes,
// FSM state encoding and default vector addresses.
package pc_controller_pkg;

  // Next-PC select encodings; codes 5-7 behave as HOLD
  localparam logic [2:0] PCX_INC  = 3'd0;
  localparam logic [2:0] PCX_ABS  = 3'd1;
  localparam logic [2:0] PCX_REL  = 3'd2;
  localparam logic [2:0] PCX_RETI = 3'd3;
  localparam logic [2:0] PCX_HOLD = 3'd4;

  // Interrupt-entry sequencer states
  typedef enum logic [1:0] {
    PC_ST_RUN      = 2'd0,
    PC_ST_INT_SAVE = 2'd1,
    PC_ST_INT_VEC  = 2'd2
  } pc_state_t;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEFAULT_INT_VECTOR   = 16'h0002;
  localparam int          DEFAULT_PC_STEP      = 2;

endpackage

// File: rtl/pc_controller_if.sv
// Bus bundle between the pipeline control (master) and the PC stage (slave).
interface pc_controller_if;
  logic        pc_en;
  logic [2:0]  pcx;
  logic        cond;
  logic [15:0] jump_addr;
  logic [15:0] rel_offset;
  logic        int_req;
  logic        int_en;
  logic [15:0] pc_a;
  logic [15:0] ret_addr;
  logic        in_isr;
  logic        int_ack;
  logic        pc_fault;

  modport master (
    output pc_en, pcx, cond, jump_addr, rel_offset, int_req, int_en,
    input  pc_a, ret_addr, in_isr, int_ack, pc_fault
  );

  modport slave (
    input  pc_en, pcx, cond, jump_addr, rel_offset, int_req, int_en,
    output pc_a, ret_addr, in_isr, int_ack, pc_fault
  );
endinterface

// File: rtl/pc_controller_next_mux.sv
// Combinational next-PC selection: increment, absolute jump, relative
// branch, interrupt return or hold. All arithmetic wraps modulo 2^16.
module pc_next_mux
  import pc_controller_pkg::*;
#(
  parameter int PC_STEP = DEFAULT_PC_STEP
) (
  input  logic [15:0] pc,
  input  logic [2:0]  pcx,
  input  logic        cond,
  input  logic [15:0] jump_addr,
  input  logic [15:0] rel_offset,
  input  logic [15:0] ret_addr,
  output logic [15:0] next_pc
);

  logic [15:0] inc_pc;
  logic [15:0] rel_pc;

  // Two's-complement add handles negative offsets without sign extension
  assign inc_pc = pc + 16'(PC_STEP);
  assign rel_pc = pc + rel_offset;

  // Select the target; untaken conditional branches fall through to INC
  always_comb begin
    next_pc = pc;
    case (pcx)
      PCX_INC:  next_pc = inc_pc;
      PCX_ABS:  next_pc = cond ? jump_addr : inc_pc;
      PCX_REL:  next_pc = cond ? rel_pc : inc_pc;
      PCX_RETI: next_pc = ret_addr;
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_controller.sv
// Program-counter stage: owns PC_A, return address and the interrupt-entry
// sequencer (RUN -> INT_SAVE -> INT_VEC -> RUN).
// Optional macro PC_ALIGN_CHECK_EN: forces jump/branch/return targets and
// saved return addresses even, and pulses pc_fault on a corrected load.
module pc_controller
  import pc_controller_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [15:0] INT_VECTOR   = DEFAULT_INT_VECTOR,
  parameter int          PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_controller_if.slave bus
);

  pc_state_t   state;
  logic [15:0] pc_a_reg;
  logic [15:0] ret_addr_reg;
  logic        in_isr_reg;
  logic        int_ack_reg;
  logic        pc_fault_reg;

  logic [15:0] next_pc;
  logic [15:0] load_pc;
  logic [15:0] ret_capture;
  logic        load_fault;
  logic        take_int;

  pc_next_mux #(
    .PC_STEP (PC_STEP)
  ) u_next_mux (
    .pc         (pc_a_reg),
    .pcx        (bus.pcx),
    .cond       (bus.cond),
    .jump_addr  (bus.jump_addr),
    .rel_offset (bus.rel_offset),
    .ret_addr   (ret_addr_reg),
    .next_pc    (next_pc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic target_load;

  // Only loads from an external target can introduce an odd address
  always_comb begin
    target_load = 1'b0;
    case (bus.pcx)
      PCX_ABS:  target_load = bus.cond;
      PCX_REL:  target_load = bus.cond;
      PCX_RETI: target_load = 1'b1;
      default:  target_load = 1'b0;
    endcase
  end

  assign load_fault  = target_load & next_pc[0];
  assign load_pc     = {next_pc[15:1], next_pc[0] & ~target_load};
  assign ret_capture = {next_pc[15:1], 1'b0};
`else
  assign load_fault  = 1'b0;
  assign load_pc     = next_pc;
  assign ret_capture = next_pc;
`endif

  // RETI always beats a pending request so the handler can exit cleanly
  assign take_int = bus.int_req & bus.int_en & ~in_isr_reg & (bus.pcx != PCX_RETI);

  // Sequencer and all architectural registers; ack and fault are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PC_ST_RUN;
      pc_a_reg     <= RESET_VECTOR;
      ret_addr_reg <= 16'h0000;
      in_isr_reg   <= 1'b0;
      int_ack_reg  <= 1'b0;
      pc_fault_reg <= 1'b0;
    end else begin
      int_ack_reg  <= 1'b0;
      pc_fault_reg <= 1'b0;
      case (state)
        PC_ST_RUN: begin
          if (bus.pc_en) begin
            if (take_int) begin
              // Save the target the interrupted instruction would have reached
              ret_addr_reg <= ret_capture;
              int_ack_reg  <= 1'b1;
              state        <= PC_ST_INT_SAVE;
            end else begin
              pc_a_reg     <= load_pc;
              pc_fault_reg <= load_fault;
              if (bus.pcx == PCX_RETI) begin
                in_isr_reg <= 1'b0;
              end
            end
          end
        end
        PC_ST_INT_SAVE: begin
          in_isr_reg <= 1'b1;
          state      <= PC_ST_INT_VEC;
        end
        PC_ST_INT_VEC: begin
          pc_a_reg <= INT_VECTOR;
          state    <= PC_ST_RUN;
        end
        default: begin
          state <= PC_ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_a     = pc_a_reg;
  assign bus.ret_addr = ret_addr_reg;
  assign bus.in_isr   = in_isr_reg;
  assign bus.int_ack  = int_ack_reg;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.pc_fault = pc_fault_reg;
`else
  assign bus.pc_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Directed testbench for pc_controller.
module tb_pc_controller;
  import pc_controller_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_controller_if bus ();

  pc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set, sample 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] sel, input logic c,
                       input logic [15:0] ja, input logic [15:0] off);
    bus.pc_en      = en;
    bus.pcx        = sel;
    bus.cond       = c;
    bus.jump_addr  = ja;
    bus.rel_offset = off;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, PCX_HOLD, 1'b0, 16'h0000, 16'h0000);
    bus.int_req = 1'b0;
    bus.int_en  = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_pc", bus.pc_a, 16'h0000);
    chk("rst_ret", bus.ret_addr, 16'h0000);
    chk("rst_isr", 16'(bus.in_isr), 16'h0000);
    chk("rst_ack", 16'(bus.int_ack), 16'h0000);
    chk("rst_fault", 16'(bus.pc_fault), 16'h0000);
    rst_n = 1'b1;

    // Sequential increment
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    step(); chk("inc1", bus.pc_a, 16'h0002);
    step(); chk("inc2", bus.pc_a, 16'h0004);
    step(); chk("inc3", bus.pc_a, 16'h0006);

    // Wrap at top of address space
    drive(1'b1, PCX_ABS, 1'b1, 16'hFFFE, 16'h0000);
    step(); chk("abs_fffe", bus.pc_a, 16'hFFFE);
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    step(); chk("inc_wrap", bus.pc_a, 16'h0000);

    // Relative branch taken with negative offset
    drive(1'b1, PCX_ABS, 1'b1, 16'h0100, 16'h0000);
    step(); chk("abs_0100", bus.pc_a, 16'h0100);
    drive(1'b1, PCX_REL, 1'b1, 16'h0000, 16'hFFF0);
    step(); chk("rel_taken", bus.pc_a, 16'h00F0);

    // Relative branch not taken falls through
    drive(1'b1, PCX_ABS, 1'b1, 16'h0100, 16'h0000);
    step();
    drive(1'b1, PCX_REL, 1'b0, 16'h0000, 16'hFFF0);
    step(); chk("rel_untaken", bus.pc_a, 16'h0102);

    // Absolute jump taken, then untaken
    drive(1'b1, PCX_ABS, 1'b1, 16'h1234, 16'h0000);
    step(); chk("abs_1234", bus.pc_a, 16'h1234);
    drive(1'b1, PCX_ABS, 1'b0, 16'h4000, 16'h0000);
    step(); chk("abs_untaken", bus.pc_a, 16'h1236);

    // Advance strobe low: nothing moves
    drive(1'b0, PCX_ABS, 1'b1, 16'h5678, 16'h0000);
    step(); chk("en_low", bus.pc_a, 16'h1236);

    // HOLD and reserved select codes
    drive(1'b1, PCX_HOLD, 1'b1, 16'h5678, 16'h0000);
    step(); chk("hold", bus.pc_a, 16'h1236);
    drive(1'b1, 3'd7, 1'b1, 16'h5678, 16'h0000);
    step(); chk("pcx7", bus.pc_a, 16'h1236);

    // Request with global enable low is ignored
    bus.int_req = 1'b1;
    bus.int_en  = 1'b0;
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    step(); chk("inten0_pc", bus.pc_a, 16'h1238);
    chk("inten0_ack", 16'(bus.int_ack), 16'h0000);

    // Interrupt entry from 0200
    bus.int_req = 1'b0;
    drive(1'b1, PCX_ABS, 1'b1, 16'h0200, 16'h0000);
    step();
    bus.int_req = 1'b1;
    bus.int_en  = 1'b1;
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("acc_pc", bus.pc_a, 16'h0200);
    chk("acc_ret", bus.ret_addr, 16'h0202);
    chk("acc_ack", 16'(bus.int_ack), 16'h0001);
    chk("acc_isr", 16'(bus.in_isr), 16'h0000);
    bus.int_req = 1'b0;  // dropping the request must not cancel entry
    step();
    chk("save_ack", 16'(bus.int_ack), 16'h0000);
    chk("save_isr", 16'(bus.in_isr), 16'h0001);
    chk("save_pc", bus.pc_a, 16'h0200);
    step();
    chk("vec_pc", bus.pc_a, 16'h0002);
    chk("vec_isr", 16'(bus.in_isr), 16'h0001);

    // No nesting while in the handler
    bus.int_req = 1'b1;
    step();
    chk("isr_inc_pc", bus.pc_a, 16'h0004);
    chk("isr_no_ack", 16'(bus.int_ack), 16'h0000);
    chk("isr_ret_kept", bus.ret_addr, 16'h0202);

    // RETI beats pending request
    drive(1'b1, PCX_RETI, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("reti_pc", bus.pc_a, 16'h0202);
    chk("reti_isr", 16'(bus.in_isr), 16'h0000);
    chk("reti_ack", 16'(bus.int_ack), 16'h0000);

    // Pending request taken on next advance
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("reacc_ack", 16'(bus.int_ack), 16'h0001);
    chk("reacc_ret", bus.ret_addr, 16'h0204);
    chk("reacc_pc", bus.pc_a, 16'h0202);
    bus.int_req = 1'b0;
    step();
    step();
    chk("reacc_vec", bus.pc_a, 16'h0002);

    // RETI outside the handler loads RET_ADDR, IN_ISR stays clear
    drive(1'b1, PCX_RETI, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("reti2_pc", bus.pc_a, 16'h0204);
    drive(1'b1, PCX_ABS, 1'b1, 16'h0300, 16'h0000);
    step();
    drive(1'b1, PCX_RETI, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("reti_noisr_pc", bus.pc_a, 16'h0204);
    chk("reti_noisr_isr", 16'(bus.in_isr), 16'h0000);

    // Reset immediately after the accepting edge abandons the entry
    drive(1'b1, PCX_ABS, 1'b1, 16'h0400, 16'h0000);
    step();
    bus.int_req = 1'b1;
    drive(1'b1, PCX_INC, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_pc", bus.pc_a, 16'h0000);
    chk("rstmid_ack", 16'(bus.int_ack), 16'h0000);
    chk("rstmid_isr", 16'(bus.in_isr), 16'h0000);
    chk("rstmid_ret", bus.ret_addr, 16'h0000);
    bus.int_req = 1'b0;
    drive(1'b0, PCX_HOLD, 1'b0, 16'h0000, 16'h0000);
    step();
    rst_n = 1'b1;
    step(); chk("post_ack1", 16'(bus.int_ack), 16'h0000);
    step(); chk("post_ack2", 16'(bus.int_ack), 16'h0000);
    chk("post_pc", bus.pc_a, 16'h0000);
    chk("post_isr", 16'(bus.in_isr), 16'h0000);

    // Odd absolute target
    drive(1'b1, PCX_ABS, 1'b1, 16'h1235, 16'h0000);
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("odd_pc", bus.pc_a, 16'h1234);
    chk("odd_fault", 16'(bus.pc_fault), 16'h0001);
`else
    chk("odd_pc", bus.pc_a, 16'h1235);
    chk("odd_fault", 16'(bus.pc_fault), 16'h0000);
`endif
    drive(1'b1, PCX_HOLD, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("fault_clear", 16'(bus.pc_fault), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_controller.md
Name: pc_controller

Overview:
Program-counter stage directly upstream of the address bus controller.
- Owns the PC register and drives PC_A, the fetch address the bus controller selects in fetch cycles.
- Computes the next PC: increment, absolute jump, PC-relative branch, interrupt return.
- Sequences interrupt entry through a small FSM that saves the return address and vectors to a fixed handler.

Parameters:
RESET_VECTOR, 16'h0000, PC_A value on reset.
INT_VECTOR, 16'h0002, handler address loaded on interrupt entry.
PC_STEP, 2, increment per instruction (byte address, 16-bit instructions).

Ports:
CLK  input  1  system clock, rising edge.
RESET_N  input  1  asynchronous active-low reset.
PC_EN  input  1  advance strobe; PC updates only when high.
PCX  input  3  next-PC select: INC=0, ABS=1, REL=2, RETI=3, HOLD=4; 5-7 treated as HOLD.
COND  input  1  branch condition; qualifies ABS and REL.
JUMP_ADDR  input  16  absolute target, normally ALU_R.
REL_OFFSET  input  16  signed two's-complement offset for REL.
INT_REQ  input  1  level interrupt request.
INT_EN  input  1  global interrupt enable.
PC_A  output  16  current program counter.
RET_ADDR  output  16  saved return address.
IN_ISR  output  1  high while servicing an interrupt.
INT_ACK  output  1  one-cycle acknowledge pulse.
PC_FAULT  output  1  misalignment flag; only with the optional feature.

Behaviour:
- Reset, asynchronous, while RESET_N=0:
  - PC_A=RESET_VECTOR, RET_ADDR=0000, IN_ISR=0, INT_ACK=0, PC_FAULT=0, state=RUN.
  - Reset mid-interrupt-entry abandons the entry; no ACK is issued.
- Next-PC, combinational; all arithmetic is 16-bit modulo 2^16:
  - INC: PC_A+PC_STEP. FFFE wraps to 0000.
  - ABS: JUMP_ADDR if COND=1, else INC.
  - REL: PC_A+REL_OFFSET if COND=1, else INC. Offset is full 16-bit signed; wraps.
  - RETI: RET_ADDR.
  - HOLD: PC_A.
- FSM states RUN, INT_SAVE, INT_VEC:
  - RUN, PC_EN=1, INT_REQ & INT_EN & !IN_ISR, PCX!=RETI:
    - RET_ADDR <= next-PC (target of the current instruction).
    - PC_A unchanged; go INT_SAVE.
  - RUN, PC_EN=1, no interrupt taken: PC_A <= next-PC.
    - If PCX=RETI, also IN_ISR <= 0.
  - RUN, PC_EN=0: all registers hold. Interrupts are sampled only on PC_EN=1.
  - INT_SAVE: INT_ACK=1 for this cycle only; IN_ISR <= 1; go INT_VEC. PC_EN ignored.
  - INT_VEC: PC_A <= INT_VECTOR; go RUN. PC_EN ignored.
- Entry latency: 2 cycles from the accepting edge to PC_A=INT_VECTOR.
- Nesting:
  - INT_REQ is ignored while IN_ISR=1. No nesting.
  - RETI together with a pending request: RETI wins, IN_ISR clears. The request is taken on the next PC_EN=1.
- INT_REQ deasserting during INT_SAVE/INT_VEC does not cancel entry.
- RETI with IN_ISR=0: loads RET_ADDR; IN_ISR stays 0.
- Registered outputs only; no combinational path from inputs to PC_A.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - A load of PC_A from ABS, REL or RETI with bit0=1 forces bit0 to 0.
  - PC_FAULT pulses high for exactly one cycle after that edge.
  - RET_ADDR captures are likewise forced even; these do not set the fault.
- Undefined:
  - Targets are loaded unmodified.
  - PC_FAULT is tied to 0, and the port is still present.

Decomposition:
- Shared constants package:
  - PCX_INC/ABS/REL/RETI/HOLD encodings (3-bit).
  - FSM state encodings PC_ST_RUN/INT_SAVE/INT_VEC.
  - Default RESET_VECTOR/INT_VECTOR.
- One natural sub-module: pc_next_mux, a combinational next-PC selection and adder. It takes PC_A, PCX, COND, JUMP_ADDR, REL_OFFSET and RET_ADDR, and outputs next-PC.
- FSM and registers stay in pc_controller.

Test Plan:
- Reset, then PC_EN=1, PCX=INC for 3 cycles -> PC_A 0000, 0002, 0004, 0006. Preload PC_A=FFFE, then INC -> 0000.
- PC_A=0100, PCX=REL, REL_OFFSET=FFF0:
  - COND=1 -> PC_A=00F0.
  - COND=0 -> PC_A=0102.
  - ABS with COND=1, JUMP_ADDR=1234 -> PC_A=1234.
- PC_A=0200, INC, INT_REQ=1, INT_EN=1 at PC_EN edge:
  - RET_ADDR=0202.
  - INT_ACK high 1 cycle next.
  - PC_A=0002 two cycles after accept; IN_ISR=1.
  - Then PCX=RETI -> PC_A=0202, IN_ISR=0.
- IN_ISR=1, INT_REQ held high, INC -> no second ACK. RETI with INT_REQ high -> PC_A=RET_ADDR, and entry occurs on the following PC_EN edge.
- PC_EN=0 with PCX=ABS, COND=1 -> PC_A unchanged. RESET_N low during INT_SAVE -> PC_A=0000, INT_ACK never asserts, IN_ISR=0.
- With PC_ALIGN_CHECK_EN: ABS to 1235 -> PC_A=1234, PC_FAULT high 1 cycle. Without it -> PC_A=1235, PC_FAULT=0.
